// File: rtl/nand_rd_capture.sv
`default_nettype none
// ============================================================================
// Module  : nand_rd_capture
// Purpose : Captures DQ rise/fall pairs after the read latency, packs them into
//           words and buffers them in a FIFO with a valid/ready output side.
//           Define NAND_RD_XSUM_EN to add the rd_xsum burst checksum port.
// Rev     : 1.0  initial release
// ============================================================================
module nand_rd_capture #(
    parameter int DQ_WIDTH   = 8,
    parameter int RD_LATENCY = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  rd_start,
    input  logic [CNT_WIDTH-1:0]  rd_len,
    input  logic [DQ_WIDTH-1:0]   dq_rd_rise,
    input  logic [DQ_WIDTH-1:0]   dq_rd_fall,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic [2*DQ_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic                  overflow
`ifdef NAND_RD_XSUM_EN
    ,
    output logic [2*DQ_WIDTH-1:0] rd_xsum
`endif
);

    localparam int                   c_AW       = $clog2(FIFO_DEPTH);
    localparam int                   c_WW       = 2 * DQ_WIDTH;
    localparam logic [3:0]           c_LAT_INIT = 4'(RD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [c_AW:0]        c_PTR_ONE  = (c_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_lat_cnt;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic [c_AW:0]         r_wptr;
    logic [c_AW:0]         r_rptr;
    logic [c_WW-1:0]       r_mem [FIFO_DEPTH];
    logic                  r_overflow;

    logic                  w_start_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic [c_WW-1:0]       w_word;

    assign w_start_ok = rd_start && (r_state == S_IDLE);
    assign w_push     = (r_state == S_CAPT);
    assign w_word     = {dq_rd_fall, dq_rd_rise};
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                        (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop      = !w_empty && rdata_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (rd_start) begin
                    if (rd_len == '0)
                        w_state_nxt = S_DONE;
                    else if (RD_LATENCY == 1)
                        w_state_nxt = S_CAPT;
                    else
                        w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt <= 4'd1)
                    w_state_nxt = S_CAPT;
            end
            S_CAPT: begin
                if (r_word_cnt == c_CNT_ONE)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_lat_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (w_start_ok) begin
            r_lat_cnt  <= c_LAT_INIT;
            r_word_cnt <= rd_len;
        end else begin
            if (r_state == S_WAIT)
                r_lat_cnt <= r_lat_cnt - 4'd1;
            // Dropped words still count toward the burst length.
            if (w_push)
                r_word_cnt <= r_word_cnt - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk0) begin
        if (w_wr_en)
            r_mem[r_wptr[c_AW-1:0]] <= w_word;
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)
                r_rptr <= r_rptr + c_PTR_ONE;
            if (w_start_ok)
                r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

`ifdef NAND_RD_XSUM_EN
    logic [c_WW-1:0] r_xsum;

    always_ff @(posedge clk0) begin
        if (rst0)
            r_xsum <= '0;
        else if (w_start_ok)
            r_xsum <= '0;
        else if (w_push)
            r_xsum <= r_xsum ^ w_word;
    end

    assign rd_xsum = r_xsum;
`endif

    assign rd_busy     = (r_state != S_IDLE);
    assign rd_done     = (r_state == S_DONE);
    assign rdata_valid = !w_empty;
    assign rdata       = w_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nand_rd_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_nand_rd_capture
// Purpose : Directed self-checking bench for nand_rd_capture.
// Rev     : 1.0  initial release
// ============================================================================
module tb_nand_rd_capture;

    localparam int c_LAT   = 4;
    localparam int c_DEPTH = 16;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        rd_start;
    logic [15:0] rd_len;
    logic [7:0]  dq_rd_rise;
    logic [7:0]  dq_rd_fall;
    logic        rd_busy;
    logic        rd_done;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic        overflow;
`ifdef NAND_RD_XSUM_EN
    logic [15:0] rd_xsum;
`endif

    nand_rd_capture #(
        .DQ_WIDTH   (8),
        .RD_LATENCY (c_LAT),
        .FIFO_DEPTH (c_DEPTH),
        .CNT_WIDTH  (16)
    ) u_dut (
        .clk0        (clk0),
        .rst0        (rst0),
        .rd_start    (rd_start),
        .rd_len      (rd_len),
        .dq_rd_rise  (dq_rd_rise),
        .dq_rd_fall  (dq_rd_fall),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .overflow    (overflow)
`ifdef NAND_RD_XSUM_EN
        ,
        .rd_xsum     (rd_xsum)
`endif
    );

    always #5 clk0 = ~clk0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] pat_q[$];
    int          done_cyc, done_cnt, busy_cnt, ovf_cyc, vld_cyc;
    logic [15:0] xsum_done, xsum_at1;
    logic        hold_armed = 1'b0;
    logic [15:0] hold_val   = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    // Consumer side: record accepted words and check head stability under backpressure.
    always @(negedge clk0) begin
        if (hold_armed && rdata_valid)
            chk("hold", 32'(rdata), 32'(hold_val));
        if (rdata_valid && rdata_ready)
            got_q.push_back(rdata);
        hold_armed = rdata_valid && !rdata_ready && !rst0;
        hold_val   = rdata;
    end

    // rmode: 0 ready high, 1 ready low, 2 ready toggling
    task automatic do_burst(input int len, input int base, input int rmode, input bit extra_start);
        logic [15:0] w;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; ovf_cyc = -1; vld_cyc = -1;
        xsum_done = '0; xsum_at1 = '0;
        for (int cyc = 0; cyc < c_LAT + len + 4; cyc++) begin
            rd_start    = (cyc == 0) || (extra_start && cyc == 2);
            rd_len      = (cyc == 0) ? 16'(len) : 16'd3;
            rdata_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ((cyc % 2) == 0);
            if (cyc >= c_LAT && cyc < c_LAT + len) begin
                if (pat_q.size() > 0)
                    w = pat_q[cyc - c_LAT];
                else
                    w = {8'(base + 2 * (cyc - c_LAT) + 1), 8'(base + 2 * (cyc - c_LAT))};
                exp_q.push_back(w);
            end else begin
                w = 16'hDDEE;
            end
            dq_rd_rise = w[7:0];
            dq_rd_fall = w[15:8];
            tick();
            if (rd_busy) busy_cnt++;
            if (rd_done) begin
                done_cnt++;
                done_cyc = cyc + 1;
`ifdef NAND_RD_XSUM_EN
                xsum_done = rd_xsum;
`endif
            end
`ifdef NAND_RD_XSUM_EN
            if (cyc == 0) xsum_at1 = rd_xsum;
`endif
            if (overflow && ovf_cyc < 0) ovf_cyc = cyc + 1;
            if (rdata_valid && vld_cyc < 0) vld_cyc = cyc + 1;
        end
        rd_start = 1'b0;
    endtask

    task automatic drain();
        rdata_ready = 1'b1;
        for (int i = 0; i < 64 && rdata_valid; i++)
            tick();
        chk("drain_empty", 32'(rdata_valid), 32'd0);
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e;
        rst0 = 1'b1; rd_start = 1'b0; rd_len = '0;
        dq_rd_rise = '0; dq_rd_fall = '0; rdata_ready = 1'b0;
        tick(); tick();
        chk("rst_busy",  32'(rd_busy),     32'd0);
        chk("rst_done",  32'(rd_done),     32'd0);
        chk("rst_valid", 32'(rdata_valid), 32'd0);
        chk("rst_rdata", 32'(rdata),       32'd0);
        chk("rst_ovf",   32'(overflow),    32'd0);
        rst0 = 1'b0;
        tick();

        // 1: four-word burst, consumer always ready
        do_burst(4, 1, 0, 1'b0);
        chk("t1_done_cyc", done_cyc, c_LAT + 4);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_cnt", busy_cnt, c_LAT + 4);
        chk("t1_first_vld", vld_cyc, c_LAT + 1);
        chk("t1_ovf", ovf_cyc, -1);
        drain();
        chk("t1_w0", 32'(exp_q[0]), 32'h0201);
        check_words("t1_word");

        // 2: zero-length burst
        do_burst(0, 1, 0, 1'b0);
        chk("t2_done_cyc", done_cyc, 1);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_busy_cnt", busy_cnt, 1);
        drain();
        check_words("t2_word");

        // 3: overflow with consumer stalled
        do_burst(20, 1, 1, 1'b0);
        chk("t3_ovf_cyc", ovf_cyc, c_LAT + 17);
        chk("t3_done_cyc", done_cyc, c_LAT + 20);
        chk("t3_done_cnt", done_cnt, 1);
        while (exp_q.size() > c_DEPTH) void'(exp_q.pop_back());
        drain();
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        check_words("t3_word");

        // 4: toggling ready, stray rd_start during WAIT must be ignored
        do_burst(8, 8'h30, 2, 1'b1);
        chk("t4_ovf_cleared", ovf_cyc, -1);
        chk("t4_done_cyc", done_cyc, c_LAT + 8);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_busy_cnt", busy_cnt, c_LAT + 8);
        drain();
        check_words("t4_word");

        // 5: reset in CAPT after three captures
        rdata_ready = 1'b0;
        done_cnt = 0;
        for (int cyc = 0; cyc <= c_LAT + 3; cyc++) begin
            rd_start   = (cyc == 0);
            rd_len     = 16'd8;
            rst0       = (cyc == c_LAT + 3);
            dq_rd_rise = 8'(8'h50 + cyc);
            dq_rd_fall = 8'(8'h60 + cyc);
            tick();
        end
        rst0 = 1'b0; rd_start = 1'b0;
        chk("t5_busy",  32'(rd_busy),     32'd0);
        chk("t5_done",  32'(rd_done),     32'd0);
        chk("t5_valid", 32'(rdata_valid), 32'd0);
        chk("t5_rdata", 32'(rdata),       32'd0);
        chk("t5_ovf",   32'(overflow),    32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_done) done_cnt++;
        end
        chk("t5_no_done", done_cnt, 0);
        got_q.delete();
        do_burst(2, 8'h41, 0, 1'b0);
        chk("t5_done_cyc", done_cyc, c_LAT + 2);
        drain();
        check_words("t5_word");

`ifdef NAND_RD_XSUM_EN
        // 6: burst checksum
        pat_q = '{16'h00FF, 16'hFF00, 16'h1234};
        e = '0;
        foreach (pat_q[i]) e ^= pat_q[i];
        do_burst(3, 0, 0, 1'b0);
        chk("t6_xsum_done", 32'(xsum_done), 32'(e));
        chk("t6_xsum_hold", 32'(rd_xsum), 32'(e));
        drain();
        check_words("t6_word");
        pat_q.delete();
        do_burst(1, 8'h11, 0, 1'b0);
        chk("t6_xsum_clr", 32'(xsum_at1), 32'd0);
        chk("t6_xsum_one", 32'(xsum_done), 32'h1211);
        drain();
        check_words("t6_word2");
`else
        e = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
